// File: rtl/sys_regs_ctrl.sv
// Integer register file: two registered read ports, gated write port, x0 = 0,
// halt/read-hold control and a sequenced clear engine. Option: SYS_REGS_BYPASS_EN.
module sys_regs_ctrl #(
   parameter int XLEN     = 32,
   parameter int ADDR_W   = 5,
   parameter int NUM_REGS = 32,
   parameter int OPCODE_W = 7
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                halt,
   input  logic                halt_fetch,
   input  logic [OPCODE_W-1:0] opcode_in,
   input  logic [ADDR_W-1:0]   rs1_addr,
   input  logic [ADDR_W-1:0]   rs2_addr,
   input  logic [ADDR_W-1:0]   rd_addr,
   input  logic [XLEN-1:0]     write_data,
   input  logic                clear_req,
   output logic [XLEN-1:0]     rs1_data,
   output logic [XLEN-1:0]     rs2_data,
   output logic                rs_valid,
   output logic                busy
);

   localparam logic [OPCODE_W-1:0] OP_STORE  = OPCODE_W'(7'b0100011);
   localparam logic [OPCODE_W-1:0] OP_BRANCH = OPCODE_W'(7'b1100011);
   localparam logic [ADDR_W-1:0]   LAST_IDX  = ADDR_W'(NUM_REGS - 1);
   localparam logic [ADDR_W:0]     NUM_EXT   = (ADDR_W + 1)'(NUM_REGS);

   typedef enum logic {IDLE, CLEAR} state_t;

   state_t            state;
   logic [ADDR_W-1:0] clr_idx;
   logic [XLEN-1:0]   regs [NUM_REGS];
   logic              we;
   logic [XLEN-1:0]   rs1_next;
   logic [XLEN-1:0]   rs2_next;

   // x0 and unimplemented addresses are excluded from both reads and writes
   function automatic logic in_range(input logic [ADDR_W-1:0] a);
      return (a != '0) && ({1'b0, a} < NUM_EXT);
   endfunction

   // A clear request in IDLE takes priority over a coincident write
   always_comb begin
      we = !halt && !busy && !clear_req &&
           (opcode_in != OP_STORE) && (opcode_in != OP_BRANCH) &&
           in_range(rd_addr);
   end

   always_comb begin
      rs1_next = '0;
      rs2_next = '0;
      if (in_range(rs1_addr)) rs1_next = regs[rs1_addr];
      if (in_range(rs2_addr)) rs2_next = regs[rs2_addr];
`ifdef SYS_REGS_BYPASS_EN
      if (we && (rs1_addr == rd_addr)) rs1_next = write_data;
      if (we && (rs2_addr == rd_addr)) rs2_next = write_data;
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= '0;
         state    <= IDLE;
         clr_idx  <= '0;
         busy     <= 1'b0;
         rs1_data <= '0;
         rs2_data <= '0;
         rs_valid <= 1'b0;
      end else begin
         if (we) regs[rd_addr] <= write_data;

         case (state)
            IDLE: begin
               if (clear_req) begin
                  state   <= CLEAR;
                  busy    <= 1'b1;
                  clr_idx <= ADDR_W'(1);
               end
            end
            CLEAR: begin
               regs[clr_idx] <= '0;
               if (clr_idx == LAST_IDX) begin
                  state   <= IDLE;
                  busy    <= 1'b0;
                  clr_idx <= '0;
               end else begin
                  clr_idx <= clr_idx + ADDR_W'(1);
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase

         if (busy) begin
            rs1_data <= '0;
            rs2_data <= '0;
            rs_valid <= 1'b0;
         end else if (halt_fetch) begin
            rs_valid <= 1'b0;
         end else begin
            rs1_data <= rs1_next;
            rs2_data <= rs2_next;
            rs_valid <= 1'b1;
         end
      end
   end

endmodule

// File: doc/sys_regs_ctrl.md
# sys_regs_ctrl

Parametrised successor of the integer register-file interface. Provides two registered read ports and one gated write port with x0 hardwired to zero. Adds opcode-based write suppression for STORE and BRANCH, a halt-driven read-hold, and a sequenced register-clear engine. Sits between decode (read addresses), writeback (write address/data) and the pipeline controller (halt, clear).

## Interface
Parameters:
- `XLEN`, default 32: register data width.
- `ADDR_W`, default 5: register address width.
- `NUM_REGS`, default 32: implemented registers; must satisfy 2 ≤ `NUM_REGS` ≤ 2^`ADDR_W`.
- `OPCODE_W`, default 7: opcode width.

Ports:
- `clk`, in, 1: system clock.
- `rst_n`, in, 1: reset; asynchronous, active-low.
- `halt`, in, 1: suppresses writes.
- `halt_fetch`, in, 1: holds read outputs.
- `opcode_in`, in, `OPCODE_W`: opcode of the writeback instruction.
- `rs1_addr`, in, `ADDR_W`: read port 1 address.
- `rs2_addr`, in, `ADDR_W`: read port 2 address.
- `rd_addr`, in, `ADDR_W`: write address.
- `write_data`, in, `XLEN`: write data.
- `clear_req`, in, 1: single-cycle pulse; zeroes all registers.
- `rs1_data`, out, `XLEN`: registered read data, port 1.
- `rs2_data`, out, `XLEN`: registered read data, port 2.
- `rs_valid`, out, 1: `rs1_data`/`rs2_data` hold a fresh read.
- `busy`, out, 1: clear engine active.

## Operation
- Write enable `we` = !`halt` & !`busy` & (`opcode_in` ≠ STORE 7'b0100011) & (`opcode_in` ≠ BRANCH 7'b1100011) & (`rd_addr` ≠ 0) & (`rd_addr` < `NUM_REGS`).
- When `we` is high, `regs[rd_addr]` ← `write_data` at the rising edge.
- Register x0 always reads 0 and is never written.
- Addresses ≥ `NUM_REGS` read 0. Writes to such addresses are dropped.
- Read: when !`halt_fetch` and !`busy`, `rs1_data`/`rs2_data` ← `regs[rs1_addr]`/`regs[rs2_addr]` at the edge, and `rs_valid` ← 1.
- When `halt_fetch` is high and !`busy`, the data outputs hold their value and `rs_valid` ← 0.
- Clear FSM:
  - States IDLE and CLEAR, plus a counter `clr_idx` of width `ADDR_W`.
  - IDLE → CLEAR on `clear_req`; `clr_idx` ← 1.
  - In CLEAR, each cycle `regs[clr_idx]` ← 0 and `clr_idx` increments.
  - When `clr_idx` == `NUM_REGS`-1 is written, the FSM returns to IDLE.
- `busy` = (state == CLEAR).
- While `busy`: `rs_valid` ← 0, the data outputs ← 0, and normal writes are ignored.
- `clear_req` while `busy` is ignored; no restart.
- `clear_req` coincident with a valid write: the clear wins and the write is dropped.

## Timing
- Reset values: all `regs` = 0; `rs1_data` = `rs2_data` = 0; `rs_valid` = 0; `busy` = 0; state IDLE; `clr_idx` = 0.
- Reset asserted mid-clear returns the FSM to IDLE immediately, with all registers zeroed.
- Read latency is 1 cycle: the address presented in cycle N appears on the outputs and `rs_valid` in cycle N+1.
- Write latency is 1 cycle: the register is updated at the edge ending cycle N.
- Same-cycle read/write of the same address: see Configuration.
- Clear duration: `busy` rises the cycle after `clear_req` and stays high exactly `NUM_REGS`-1 cycles.
- The first valid read after a clear is issued in the cycle `busy` falls, so `rs_valid` returns one cycle later.
- `halt` and `halt_fetch` are independent. With both high, there are no writes and the outputs hold.

## Configuration
- Macro: `SYS_REGS_BYPASS_EN`.
- Defined: when `we` is high and `rs1_addr`/`rs2_addr` == `rd_addr` in the same cycle, the corresponding output captures `write_data`, i.e. write-before-read.
- Not defined: the same case captures the pre-write register value, i.e. read-before-write. The new value is visible one cycle later.
- x0 is never bypassed in either mode.

## Test plan
- Reset, then write x5 = 0xDEADBEEF with opcode 7'b0110011, then read `rs1_addr`=5 → `rs1_data` = 0xDEADBEEF and `rs_valid` = 1, one cycle after the read.
- Write x7 = 0x1234 with opcode STORE, then BRANCH; write x0 = 0xFFFF with ALU opcode → x7 and x0 both read 0.
- Hold `halt_fetch` for 3 cycles while changing `rs1_addr` → `rs1_data` holds and `rs_valid` = 0. On release, the new data arrives 1 cycle later.
- Same-cycle write x3 = 0xA5A5 with read of `rs2_addr`=3 (x3 previously 0x1) → 0xA5A5 with `SYS_REGS_BYPASS_EN` defined, else 0x1 then 0xA5A5 on the next read.
- Fill x1..x31 with non-zero values, pulse `clear_req` → `busy` high 31 cycles, a write attempted mid-clear is ignored, and all registers read 0 afterward.
- Assert `rst_n`=0 at cycle 10 of a clear → `busy` = 0 and `rs_valid` = 0 immediately, all registers read 0 after release.
